// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// FSM state encodings and the pattern-length width helper.
package seq_det_pkg;

  typedef logic [0:0] state_t;

  // IDLE: unconfigured or last configuration was rejected.
  // HUNT: a valid pattern is loaded and the stream is being searched.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HUNT = 1'b1;

  // Width needed to hold a pattern length in the range 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter. A clear wins over a simultaneous increment;
// the count holds at all-ones instead of wrapping.
module seq_det_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count events, clamp at all-ones, clear has priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector. Shifts valid stream bits into a
// history register and compares the newest pat_len bits against the
// latched pattern. Produces a registered one-cycle detect pulse and feeds
// a saturating match counter.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seq_in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap_en,
  input  logic             clr_cnt,
  output logic             det_o,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  state_t             state;
  logic [PAT_W-1:0]   hist;
  logic [LEN_W-1:0]   fill;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  logic               len_ok;
  logic               sample;
  logic [PAT_W-1:0]   hist_next;
  logic [LEN_W-1:0]   fill_inc;
  logic [PAT_W-1:0]   len_mask;
  logic               hit;

  // Only bit positions below the active length take part in the compare.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_q);
    end
  endgenerate

  // Next history/fill values and the match decision on the updated history.
  // A cfg_load in the same cycle discards the incoming bit.
  always_comb begin
    len_ok    = (pat_len != '0) && (pat_len <= PAT_W_L);
    sample    = (state == ST_HUNT) && in_valid && !cfg_load;
    hist_next = {hist[PAT_W-2:0], seq_in};
    fill_inc  = (fill == PAT_W_L) ? fill : fill + LEN_W'(1);
    hit       = sample && (fill_inc >= len_q) &&
                (((hist_next ^ pat_q) & len_mask) == '0);
  end

  // Configuration, FSM, history shift and detect pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      hist    <= '0;
      fill    <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      det_o   <= 1'b0;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      hist  <= '0;
      fill  <= '0;
      det_o <= 1'b0;
      if (len_ok) begin
        state   <= ST_HUNT;
        pat_q   <= pattern;
        len_q   <= pat_len;
        ovl_q   <= overlap_en;
        cfg_err <= 1'b0;
      end else begin
        state   <= ST_IDLE;
        cfg_err <= 1'b1;
      end
    end else if (sample) begin
      hist  <= hist_next;
      // Non-overlapping mode restarts the fill so the next match needs
      // a completely fresh set of pat_len bits.
      fill  <= (hit && !ovl_q) ? '0 : fill_inc;
      det_o <= hit;
    end else begin
      det_o <= 1'b0;
    end
  end

  assign armed = (state == ST_HUNT);

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit),
    .clr   (clr_cnt),
    .count (match_cnt)
  );

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog. Two instances share stimulus: one with
// the default counter width, one with a 2-bit counter for saturation.
// Expected outputs come from a bit-queue reference model and are queued
// when each step is driven, then popped and compared one clock later.
module tb_seq_det_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       seq_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic       overlap_en = 1'b0;
  logic       clr_cnt = 1'b0;

  logic        det_a, armed_a, err_a;
  logic [15:0] cnt_a;
  logic        det_s, armed_s, err_s;
  logic [1:0]  cnt_s;

  always #5 clk = ~clk;

  seq_det_prog #(.PAT_W(8), .CNT_W(16)) dut (
    .clock(clk), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap_en(overlap_en), .clr_cnt(clr_cnt), .det_o(det_a),
    .match_cnt(cnt_a), .armed(armed_a), .cfg_err(err_a)
  );

  seq_det_prog #(.PAT_W(8), .CNT_W(2)) dut_s (
    .clock(clk), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap_en(overlap_en), .clr_cnt(clr_cnt), .det_o(det_s),
    .match_cnt(cnt_s), .armed(armed_s), .cfg_err(err_s)
  );

  typedef struct {
    logic        det;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
    logic        armed;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int fails   = 0;
  int pulses  = 0;

  // reference model state
  logic       m_armed = 1'b0;
  logic       m_err   = 1'b0;
  logic [7:0] m_pat   = '0;
  int         m_len   = 0;
  logic       m_ovl   = 1'b0;
  logic       m_bits[$];
  int         m_cnt   = 0;
  int         m_cnt_s = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_err = 1'b0; m_pat = '0; m_len = 0; m_ovl = 1'b0;
    m_bits.delete(); m_cnt = 0; m_cnt_s = 0;
  endtask

  // Drive one clock of stimulus, predict, wait one edge, compare.
  task automatic step(input string tag, input logic b, input logic v,
                      input logic ld, input logic clr);
    exp_t e;
    logic match;
    match = 1'b0;
    seq_in = b; in_valid = v; cfg_load = ld; clr_cnt = clr;
    if (ld) begin
      m_bits.delete();
      if (pat_len == 0 || pat_len > 8) begin
        m_armed = 1'b0; m_err = 1'b1;
      end else begin
        m_armed = 1'b1; m_err = 1'b0;
        m_pat = pattern; m_len = int'(pat_len); m_ovl = overlap_en;
      end
    end else if (m_armed && v) begin
      m_bits.push_back(b);
      if (m_bits.size() > 8) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        match = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size()-1-i] !== m_pat[i]) match = 1'b0;
      end
      if (match && !m_ovl) m_bits.delete();
    end
    if (clr) begin
      m_cnt = 0; m_cnt_s = 0;
    end else if (match) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
    e.det = match; e.cnt = 16'(m_cnt); e.cnt_s = 2'(m_cnt_s);
    e.armed = m_armed; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, "_det"},   {31'd0, det_a},   {31'd0, e.det});
    check({tag, "_cnt"},   {16'd0, cnt_a},   {16'd0, e.cnt});
    check({tag, "_armed"}, {31'd0, armed_a}, {31'd0, e.armed});
    check({tag, "_err"},   {31'd0, err_a},   {31'd0, e.err});
    check({tag, "_det_s"}, {31'd0, det_s},   {31'd0, e.det});
    check({tag, "_cnt_s"}, {30'd0, cnt_s},   {30'd0, e.cnt_s});
    if (det_a === 1'b1) pulses++;
    $display("step %s b=%0b v=%0b ld=%0b clr=%0b -> det=%0b cnt=%0d cnt_s=%0d armed=%0b err=%0b",
             tag, b, v, ld, clr, det_a, cnt_a, cnt_s, armed_a, err_a);
    seq_in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic cfg(input string tag, input logic [7:0] p, input logic [3:0] l, input logic o);
    pattern = p; pat_len = l; overlap_en = o;
    step(tag, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send(input string tag, input logic b);
    step(tag, b, 1'b1, 1'b0, 1'b0);
  endtask

  // Hold reset for two clocks, checking that everything is cleared.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check({tag, "_rst_det"},   {31'd0, det_a},   32'd0);
      check({tag, "_rst_cnt"},   {16'd0, cnt_a},   32'd0);
      check({tag, "_rst_armed"}, {31'd0, armed_a}, 32'd0);
      check({tag, "_rst_err"},   {31'd0, err_a},   32'd0);
      $display("reset %s cycle %0d armed=%0b cnt=%0d", tag, i, armed_a, cnt_a);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  logic [7:0] a5;
  logic [6:0] s1;

  initial begin
    a5 = 8'hA5;
    s1 = 7'b0101011;  // bits sent in order s1[6]..s1[0]: 0,1,0,1,0,1,1
    #2;
    do_reset("init");

    // 1: overlapping 101
    cfg("t1_cfg", 8'b101, 4'd3, 1'b1);
    for (int i = 6; i >= 0; i--) send("t1", s1[i]);
    check("t1_total", {16'd0, cnt_a}, 32'd2);

    // 2: non-overlapping 101
    do_reset("t2");
    cfg("t2_cfg", 8'b101, 4'd3, 1'b0);
    for (int i = 6; i >= 0; i--) send("t2", s1[i]);
    check("t2_total", {16'd0, cnt_a}, 32'd1);

    // 3: reset mid-stream loses partial match and configuration
    do_reset("t3a");
    cfg("t3_cfg", 8'b101, 4'd3, 1'b1);
    send("t3", 1'b1);
    send("t3", 1'b0);
    do_reset("t3b");
    cfg("t3_recfg", 8'b101, 4'd3, 1'b1);
    check("t3_armed_after_load", {31'd0, armed_a}, 32'd1);
    send("t3", 1'b1);
    check("t3_total", {16'd0, cnt_a}, 32'd0);

    // 4: full-width pattern with an in_valid gap
    do_reset("t4");
    cfg("t4_cfg", 8'hA5, 4'd8, 1'b1);
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      send("t4", a5[i]);
      if (i == 5)
        for (int g = 0; g < 3; g++) step("t4_gap", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_total", {16'd0, cnt_a}, 32'd1);

    // 5: saturation on the 2-bit counter, clear beats a match
    do_reset("t5");
    cfg("t5_cfg", 8'b1, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) send("t5", 1'b1);
    check("t5_sat", {30'd0, cnt_s}, 32'd3);
    check("t5_wide", {16'd0, cnt_a}, 32'd5);
    step("t5_clr", 1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_clr_s", {30'd0, cnt_s}, 32'd0);
    check("t5_clr_a", {16'd0, cnt_a}, 32'd0);

    // 6: invalid lengths, then recovery
    do_reset("t6");
    cfg("t6_len0", 8'b101, 4'd0, 1'b1);
    check("t6_err0", {31'd0, err_a}, 32'd1);
    cfg("t6_len9", 8'b101, 4'd9, 1'b1);
    check("t6_err9", {31'd0, err_a}, 32'd1);
    check("t6_armed9", {31'd0, armed_a}, 32'd0);
    send("t6", 1'b1);
    send("t6", 1'b0);
    send("t6", 1'b1);
    check("t6_nodet_cnt", {16'd0, cnt_a}, 32'd0);
    cfg("t6_valid", 8'b101, 4'd3, 1'b1);
    check("t6_err_cleared", {31'd0, err_a}, 32'd0);
    check("t6_armed", {31'd0, armed_a}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
